mul_seq: RTL
============

Name: mul_seq

Overview:
Parametrised sequential radix-2 shift-add multiplier. It is the successor to the fixed 4x4 combinational array multiplier in the muldiv datapath. It takes WIDTH-bit operands and produces a full 2*WIDTH-bit product. Operands are treated as signed or unsigned per operation, and the product is computed over WIDTH iterations. Valid/ready handshakes on both input and output let it sit between the tile's operand registers and the result mux.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; elaboration error outside this range.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- opsigned  input  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer takes product.
- p  output  2*WIDTH  product.
- ovf  output  1  present only with MUL_SEQ_OVF_FLAG_EN (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert in upstream reset tree): state=IDLE, in_ready=1, out_valid=0, p=0, counter=0, internal operand/accumulator regs=0. ovf=0 when present.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, opsigned, clear accumulator, counter=0, go to BUSY. Inputs are not sampled again until the next IDLE.
- BUSY: in_ready=0. One iteration per cycle for i = 0..WIDTH-1:
  - if b[i]=1, add a<<i to the 2*WIDTH accumulator; a is sign-extended when opsigned=1, zero-extended otherwise.
  - when i=WIDTH-1 and opsigned=1 and b[WIDTH-1]=1, subtract instead of adding (two's-complement weight of the MSB).
  - after iteration WIDTH-1, go to DONE.
- DONE: out_valid=1, p=accumulator. p is stable while out_valid=1 && out_ready=0. On out_valid&&out_ready, go to IDLE and clear out_valid; p keeps its last value.
- Latency: accept on edge k; out_valid is high after edge k+WIDTH.
- Minimum period between accepts: WIDTH+2 cycles (no overlap; in_ready is low in BUSY and DONE).
- Arithmetic is exact: p equals a*b as a 2*WIDTH-bit value, interpreted signed or unsigned per opsigned. The accumulator never overflows.
- Boundaries:
  - a=0 or b=0: p=0, same latency (no early termination).
  - Most-negative times most-negative, signed: p = 2^(2*WIDTH-2), positive.
  - opsigned is latched; changing it during BUSY has no effect.
  - in_valid held high through DONE is not accepted until IDLE.
  - out_ready high before out_valid is ignored.
- rst_n asserted mid-BUSY or mid-DONE: the operation is abandoned and the block returns to reset values immediately, with no spurious out_valid.

Optional Feature:
- Macro MUL_SEQ_OVF_FLAG_EN.
- Defined: output port ovf is present, registered, and valid with out_valid. ovf=1 when the product does not fit in WIDTH bits:
  - signed mode: p[2*WIDTH-1:WIDTH-1] is not all-equal.
  - unsigned mode: p[2*WIDTH-1:WIDTH] != 0.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - WIDTH min/max limits.
  - shared with the planned sequential divider.
- One sub-module, mul_seq_step: purely combinational single iteration.
  - inputs: accumulator, extended multiplicand, bit b[i], iteration index, last-iteration flag, opsigned.
  - output: next accumulator.
- The FSM, counter and handshake stay in mul_seq.

Test Plan:
- WIDTH=4, opsigned=0, a=4'hF, b=4'hF -> p=8'hE1 (225) with out_valid 4 cycles after accept; ovf=1 if enabled.
- WIDTH=4, opsigned=1: a=4'h8, b=4'h8 -> p=8'h40 (+64); a=4'h8, b=4'h7 -> p=8'hC8 (-56); a=4'hF, b=4'hF -> p=8'h01, ovf=0.
- WIDTH=8, opsigned=1, a=8'h80, b=8'h80 -> p=16'h4000. Then opsigned=0, same operands -> p=16'h4000. Then a=8'hFF, b=8'h02 signed -> p=16'hFFFE.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> p and out_valid stable, in_ready=0. Raise out_ready -> one handshake, IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst_n=0 at iteration 2 of WIDTH=8 -> out_valid=0, p=0, in_ready=1 immediately. The next operation 3*5 yields p=15 with normal latency.
- Random regression, WIDTH in {2,4,8,16}, both modes, random in_valid/out_ready throttling -> every p matches a reference model product; no lost or duplicated transactions.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential muldiv datapath (multiplier now, divider next).
// State encodings and the legal operand-width range live here.
package muldiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mul_seq_step.sv
// One radix-2 shift-add iteration of the sequential multiplier (purely combinational).
// The last iteration subtracts in signed mode because the multiplier MSB carries negative weight.
module mul_seq_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcandExt,
    input  logic               bBit,
    input  logic [CNT_W-1:0]   idx,
    input  logic               lastIter,
    input  logic               opSigned,
    output logic [2*WIDTH-1:0] accNext
);

    logic [2*WIDTH-1:0] shifted_s;

    // Add or subtract the weighted multiplicand for this multiplier bit.
    always_comb begin
        shifted_s = mcandExt << idx;
        if (!bBit) begin
            accNext = acc;
        end else if (lastIter && opSigned) begin
            accNext = acc - shifted_s;
        end else begin
            accNext = acc + shifted_s;
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes, WIDTH iterations per product.
// Optional overflow flag output is enabled with the MUL_SEQ_OVF_FLAG_EN macro.
module mul_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               opsigned,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MUL_SEQ_OVF_FLAG_EN
    output logic [2*WIDTH-1:0] p,
    output logic               ovf
`else
    output logic [2*WIDTH-1:0] p
`endif
);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : gWidthCheck
        $error("mul_seq: WIDTH out of legal range 2..32");
    end

    logic [1:0]         state_r;
    logic [1:0]         nextState_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mult_r;
    logic               opSigned_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] accNext_s;
    logic [2*WIDTH-1:0] mcandExt_s;
    logic [2*WIDTH-1:0] p_r;
    logic               inReady_r;
    logic               outValid_r;
    logic               inReadyNext_s;
    logic               outValidNext_s;
    logic               accept_s;
    logic               lastIter_s;

    assign accept_s   = (state_r == ST_IDLE) && in_valid && inReady_r;
    assign lastIter_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(WIDTH - 1));
    assign mcandExt_s = {{WIDTH{opSigned_r & mcand_r[WIDTH-1]}}, mcand_r};

    mul_seq_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uStep (
        .acc      (acc_r),
        .mcandExt (mcandExt_s),
        .bBit     (mult_r[cnt_r]),
        .idx      (cnt_r),
        .lastIter (lastIter_s),
        .opSigned (opSigned_r),
        .accNext  (accNext_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) nextState_s = ST_BUSY;
                else          nextState_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (lastIter_s) nextState_s = ST_DONE;
                else            nextState_s = ST_BUSY;
            end
            ST_DONE: begin
                if (outValid_r && out_ready) nextState_s = ST_IDLE;
                else                         nextState_s = ST_DONE;
            end
            default: nextState_s = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they can be registered.
    always_comb begin
        inReadyNext_s  = 1'b0;
        outValidNext_s = 1'b0;
        case (nextState_s)
            ST_IDLE: inReadyNext_s  = 1'b1;
            ST_BUSY: inReadyNext_s  = 1'b0;
            ST_DONE: outValidNext_s = 1'b1;
            default: inReadyNext_s  = 1'b1;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
        end else begin
            inReady_r  <= inReadyNext_s;
            outValid_r <= outValidNext_s;
        end
    end

    // Operand latch, iteration counter, accumulator and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r    <= '0;
            mult_r     <= '0;
            opSigned_r <= 1'b0;
            cnt_r      <= '0;
            acc_r      <= '0;
            p_r        <= '0;
        end else if (accept_s) begin
            mcand_r    <= a;
            mult_r     <= b;
            opSigned_r <= opsigned;
            cnt_r      <= '0;
            acc_r      <= '0;
        end else if (state_r == ST_BUSY) begin
            acc_r <= accNext_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (lastIter_s) begin
                p_r <= accNext_s;
            end
        end
    end

    assign in_ready  = inReady_r;
    assign out_valid = outValid_r;
    assign p         = p_r;

`ifdef MUL_SEQ_OVF_FLAG_EN
    logic ovf_r;
    logic ovfNext_s;

    // Product does not fit in WIDTH bits of the selected signedness.
    always_comb begin
        if (opSigned_r) begin
            ovfNext_s = ~((&accNext_s[2*WIDTH-1:WIDTH-1]) | ~(|accNext_s[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovfNext_s = |accNext_s[2*WIDTH-1:WIDTH];
        end
    end

    // Overflow flag captured together with the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (lastIter_s) begin
            ovf_r <= ovfNext_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule
